// File: rtl/cc_miss_ctl.sv
// cc_miss_ctl: I-cache miss controller, 4 outstanding refills, tag init/write/expunge sequencing (macros: ICACHE_256K, CCMISS_ERR_REFETCH_EN)
module cc_miss_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        lk_en,
  input  logic [36:0] lk_addr,
  input  logic        lk_hit,
  input  logic        lk_err,
  output logic        lk_retry,
  output logic        req_en,
  output logic [36:0] req_addr,
  output logic [1:0]  req_id,
  input  logic        req_stall,
  input  logic        rsp_en,
  input  logic [1:0]  rsp_id,
  output logic [36:0] tag_write_addr,
  output logic        tag_write_wen,
  output logic        tag_init,
  input  logic        tag_exp_en,
  input  logic [36:0] tag_exp_addr,
  output logic        exp_en,
  output logic [36:0] exp_addr,
  output logic        busy
);
  localparam int DEPTH = 4;
`ifdef ICACHE_256K
  localparam int INIT_COUNT = 256;
`else
  localparam int INIT_COUNT = 128;
`endif
  typedef enum logic {G_INIT, G_RUN} gst_t;
  typedef enum logic [1:0] {E_FREE, E_PEND, E_WAIT, E_FILL} est_t;
  typedef enum logic [1:0] {W_IDLE, W_WR, W_EXP} wst_t;
  gst_t        gst, gst_n;
  wst_t        wst, wst_n;
  est_t        est [DEPTH];
  est_t        est_n [DEPTH];
  logic [36:0] eaddr [DEPTH];
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  widx, widx_n, fidx, pidx, vidx, iidx, sidx;
  logic [3:0]  fv;
  logic        miss, dup, any_free, all_free, any_pend, any_fv, alloc, rsp_ok, stl;
  logic        unused;
  assign unused = lk_err;
`ifdef CCMISS_ERR_REFETCH_EN
  assign miss = (gst == G_RUN) && lk_en && (!lk_hit || lk_err);
`else
  assign miss = (gst == G_RUN) && lk_en && !lk_hit;
`endif
  assign rsp_ok = rsp_en && est[rsp_id] == E_WAIT;
  // Entry scan: free/pending/fill-ready sets, lowest-index picks and address dedup
  always_comb begin
    dup = 1'b0;
    any_free = 1'b0;
    all_free = 1'b1;
    any_pend = 1'b0;
    any_fv = 1'b0;
    fidx = '0;
    pidx = '0;
    vidx = '0;
    fv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (est[i] == E_FREE) begin
        any_free = 1'b1;
        fidx = 2'(i);
      end else begin
        all_free = 1'b0;
        if (eaddr[i] == lk_addr) dup = 1'b1;
      end
      if (est[i] == E_PEND) begin
        any_pend = 1'b1;
        pidx = 2'(i);
      end
      fv[i] = (est[i] == E_FILL && !(wst == W_EXP && widx == 2'(i))) || (rsp_ok && rsp_id == 2'(i));
      if (fv[i]) begin
        any_fv = 1'b1;
        vidx = 2'(i);
      end
    end
  end
  assign alloc = miss && !dup && any_free;
  assign lk_retry = (lk_en && gst == G_INIT) || (miss && !dup && !any_free);
  assign iidx = stl ? sidx : pidx;
  assign req_en = any_pend;
  assign req_addr = any_pend ? eaddr[iidx] : '0;
  assign req_id = any_pend ? iidx : '0;
  assign tag_init = gst == G_INIT;
  assign tag_write_wen = wst == W_WR;
  assign tag_write_addr = gst == G_INIT ? {29'b0, cnt} : wst == W_WR ? eaddr[widx] : '0;
  assign busy = gst == G_INIT || !all_free;
  // Next state: init sweep, entry lifecycle, tag write sequencer (EXP chains straight into the next WR)
  always_comb begin
    gst_n = gst;
    cnt_n = cnt;
    wst_n = wst;
    widx_n = widx;
    for (int i = 0; i < DEPTH; i++) est_n[i] = est[i];
    if (gst == G_INIT) begin
      gst_n = cnt == 8'(INIT_COUNT - 1) ? G_RUN : G_INIT;
      cnt_n = cnt == 8'(INIT_COUNT - 1) ? 8'd0 : cnt + 8'd1;
    end
    if (alloc) est_n[fidx] = E_PEND;
    if (req_en && !req_stall) est_n[iidx] = E_WAIT;
    if (rsp_ok) est_n[rsp_id] = E_FILL;
    if (wst == W_EXP) est_n[widx] = E_FREE;
    if (wst == W_WR) wst_n = W_EXP;
    else if (any_fv) begin
      wst_n = W_WR;
      widx_n = vidx;
    end else wst_n = W_IDLE;
  end
  // State registers, all updated on the falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      gst <= G_INIT;
      cnt <= '0;
      wst <= W_IDLE;
      widx <= '0;
      stl <= 1'b0;
      sidx <= '0;
      exp_en <= 1'b0;
      exp_addr <= '0;
      for (int i = 0; i < DEPTH; i++) est[i] <= E_FREE;
    end else begin
      gst <= gst_n;
      cnt <= cnt_n;
      wst <= wst_n;
      widx <= widx_n;
      stl <= req_en && req_stall;
      sidx <= iidx;
      exp_en <= wst == W_EXP && tag_exp_en;
      exp_addr <= (wst == W_EXP && tag_exp_en) ? tag_exp_addr : '0;
      for (int i = 0; i < DEPTH; i++) est[i] <= est_n[i];
    end
  end
  // Entry addresses are only meaningful while non-FREE, so they carry no reset
  always_ff @(negedge clk) begin
    if (!rst && alloc) eaddr[fidx] <= lk_addr;
  end
endmodule

// File: tb/tb_cc_miss_ctl.sv
// tb_cc_miss_ctl: directed self-checking bench for cc_miss_ctl
module tb_cc_miss_ctl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        lk_en = 1'b0, lk_hit = 1'b0, lk_err = 1'b0, req_stall = 1'b0, rsp_en = 1'b0, tag_exp_en = 1'b0;
  logic [36:0] lk_addr = '0, tag_exp_addr = '0;
  logic [1:0]  rsp_id = '0;
  logic        lk_retry, req_en, tag_write_wen, tag_init, exp_en, busy;
  logic [36:0] req_addr, tag_write_addr, exp_addr;
  logic [1:0]  req_id;
  int          n_cmp = 0, n_bad = 0;

  cc_miss_ctl dut (
    .clk(clk), .rst(rst), .lk_en(lk_en), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_err(lk_err),
    .lk_retry(lk_retry), .req_en(req_en), .req_addr(req_addr), .req_id(req_id), .req_stall(req_stall),
    .rsp_en(rsp_en), .rsp_id(rsp_id), .tag_write_addr(tag_write_addr), .tag_write_wen(tag_write_wen),
    .tag_init(tag_init), .tag_exp_en(tag_exp_en), .tag_exp_addr(tag_exp_addr), .exp_en(exp_en),
    .exp_addr(exp_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (tag_init !== 1'b1) begin n_bad++; $display("FAIL reset_tag_init got %0b want 1", tag_init); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %0b want 1", busy); end
    n_cmp++; if ({req_en, tag_write_wen, exp_en, lk_retry} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {req_en, tag_write_wen, exp_en, lk_retry}); end
    n_cmp++; if ({req_addr, req_id, tag_write_addr, exp_addr} !== '0) begin n_bad++; $display("FAIL reset_buses got %h want 0", {req_addr, req_id, tag_write_addr, exp_addr}); end
    @(posedge clk);
  endtask

  task automatic test_init;
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      lk_en = (i == 5);
      #1;
      n_cmp++; if (tag_init !== 1'b1 || tag_write_addr !== 37'(i)) begin n_bad++; $display("FAIL init_sweep[%0d] got init=%0b addr=%0d want init=1 addr=%0d", i, tag_init, tag_write_addr, i); end
      if (i == 5) begin
        n_cmp++; if (lk_retry !== 1'b1) begin n_bad++; $display("FAIL init_retry got %0b want 1", lk_retry); end
      end
      @(posedge clk);
    end
    lk_en = 1'b0;
    #1;
    n_cmp++; if (tag_init !== 1'b0) begin n_bad++; $display("FAIL init_done got %0b want 0", tag_init); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init_busy got %0b want 0", busy); end
    n_cmp++; if (req_en !== 1'b0) begin n_bad++; $display("FAIL init_no_req got %0b want 0", req_en); end
    @(posedge clk);
  endtask

  task automatic test_single_miss;
    lk_en = 1'b1; lk_addr = 37'h1000; lk_hit = 1'b0;
    #1;
    n_cmp++; if (lk_retry !== 1'b0) begin n_bad++; $display("FAIL single_retry got %0b want 0", lk_retry); end
    @(posedge clk);
    lk_en = 1'b0;
    #1;
    n_cmp++; if (req_en !== 1'b1 || req_id !== 2'd0 || req_addr !== 37'h1000) begin n_bad++; $display("FAIL single_req got en=%0b id=%0d addr=%h want 1/0/1000", req_en, req_id, req_addr); end
    @(posedge clk);
    rsp_en = 1'b1; rsp_id = 2'd0;
    #1;
    n_cmp++; if (req_en !== 1'b0) begin n_bad++; $display("FAIL single_req_done got %0b want 0", req_en); end
    @(posedge clk);
    rsp_en = 1'b0;
    #1;
    n_cmp++; if (tag_write_wen !== 1'b1 || tag_write_addr !== 37'h1000) begin n_bad++; $display("FAIL single_wr got wen=%0b addr=%h want 1/1000", tag_write_wen, tag_write_addr); end
    @(posedge clk);
    #1;
    n_cmp++; if (tag_write_wen !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_exp got wen=%0b busy=%0b want 0/1", tag_write_wen, busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || exp_en !== 1'b0) begin n_bad++; $display("FAIL single_free got busy=%0b exp_en=%0b want 0/0", busy, exp_en); end
    @(posedge clk);
  endtask

  task automatic test_expunge;
    lk_en = 1'b1; lk_addr = 37'h1500;
    #1; @(posedge clk);
    lk_en = 1'b0;
    #1; @(posedge clk);
    rsp_en = 1'b1; rsp_id = 2'd0;
    #1; @(posedge clk);
    rsp_en = 1'b0;
    #1;
    n_cmp++; if (tag_write_wen !== 1'b1 || tag_write_addr !== 37'h1500) begin n_bad++; $display("FAIL exp_wr got wen=%0b addr=%h want 1/1500", tag_write_wen, tag_write_addr); end
    @(posedge clk);
    tag_exp_en = 1'b1; tag_exp_addr = 37'h2A;
    #1;
    n_cmp++; if (exp_en !== 1'b0) begin n_bad++; $display("FAIL exp_early got %0b want 0", exp_en); end
    @(posedge clk);
    tag_exp_en = 1'b0; tag_exp_addr = '0;
    #1;
    n_cmp++; if (exp_en !== 1'b1 || exp_addr !== 37'h2A) begin n_bad++; $display("FAIL exp_out got en=%0b addr=%h want 1/2a", exp_en, exp_addr); end
    @(posedge clk);
    #1;
    n_cmp++; if (exp_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL exp_once got en=%0b busy=%0b want 0/0", exp_en, busy); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back;
    req_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lk_en = 1'b1; lk_addr = 37'h1000 + 37'(k);
      #1;
      n_cmp++; if (lk_retry !== 1'b0) begin n_bad++; $display("FAIL b2b_alloc[%0d] retry got %0b want 0", k, lk_retry); end
      @(posedge clk);
    end
    lk_addr = 37'h1004;
    #1;
    n_cmp++; if (lk_retry !== 1'b1) begin n_bad++; $display("FAIL b2b_full retry got %0b want 1", lk_retry); end
    @(posedge clk);
    lk_addr = 37'h1000;
    #1;
    n_cmp++; if (lk_retry !== 1'b0) begin n_bad++; $display("FAIL b2b_dedup retry got %0b want 0", lk_retry); end
    n_cmp++; if (req_en !== 1'b1 || req_id !== 2'd0 || req_addr !== 37'h1000) begin n_bad++; $display("FAIL b2b_head got en=%0b id=%0d addr=%h want 1/0/1000", req_en, req_id, req_addr); end
    @(posedge clk);
    lk_en = 1'b0; req_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (req_en !== 1'b1 || req_id !== 2'(k) || req_addr !== 37'h1000 + 37'(k)) begin n_bad++; $display("FAIL b2b_issue[%0d] got en=%0b id=%0d addr=%h", k, req_en, req_id, req_addr); end
      @(posedge clk);
    end
    #1;
    n_cmp++; if (req_en !== 1'b0) begin n_bad++; $display("FAIL b2b_no_extra got %0b want 0", req_en); end
    for (int j = 0; j < 9; j++) begin
      rsp_en = (j < 4); rsp_id = 2'(j);
      #1;
      n_cmp++; if (tag_write_wen !== 1'(j % 2) || (j % 2 == 1 && tag_write_addr !== 37'h1000 + 37'(j / 2))) begin n_bad++; $display("FAIL b2b_wr[%0d] got wen=%0b addr=%h", j, tag_write_wen, tag_write_addr); end
      @(posedge clk);
    end
    rsp_en = 1'b0; rsp_id = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain busy got %0b want 0", busy); end
    @(posedge clk);
  endtask

  task automatic test_stall;
    lk_en = 1'b1; lk_addr = 37'h2000; req_stall = 1'b1;
    #1; @(posedge clk);
    lk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_en !== 1'b1 || req_id !== 2'd0 || req_addr !== 37'h2000) begin n_bad++; $display("FAIL stall_hold[%0d] got en=%0b id=%0d addr=%h", k, req_en, req_id, req_addr); end
      @(posedge clk);
    end
    req_stall = 1'b0;
    #1;
    n_cmp++; if (req_en !== 1'b1 || req_addr !== 37'h2000) begin n_bad++; $display("FAIL stall_accept got en=%0b addr=%h want 1/2000", req_en, req_addr); end
    @(posedge clk);
    rsp_en = 1'b1; rsp_id = 2'd0;
    #1;
    n_cmp++; if (req_en !== 1'b0) begin n_bad++; $display("FAIL stall_once got %0b want 0", req_en); end
    @(posedge clk);
    rsp_en = 1'b0;
    #1; @(posedge clk);
    #1; @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_drain busy got %0b want 0", busy); end
    @(posedge clk);
  endtask

  task automatic test_err;
    logic want;
`ifdef CCMISS_ERR_REFETCH_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    lk_en = 1'b1; lk_hit = 1'b1; lk_err = 1'b0; lk_addr = 37'h4000;
    #1; @(posedge clk);
    lk_en = 1'b0;
    #1;
    n_cmp++; if (req_en !== 1'b0) begin n_bad++; $display("FAIL err_hit_only got %0b want 0", req_en); end
    @(posedge clk);
    lk_en = 1'b1; lk_err = 1'b1;
    #1;
    n_cmp++; if (lk_retry !== 1'b0) begin n_bad++; $display("FAIL err_retry got %0b want 0", lk_retry); end
    @(posedge clk);
    lk_en = 1'b0; lk_hit = 1'b0; lk_err = 1'b0;
    #1;
    n_cmp++; if (req_en !== want) begin n_bad++; $display("FAIL err_alloc got %0b want %0b", req_en, want); end
    @(posedge clk);
    rsp_en = 1'b1; rsp_id = 2'd0;
    #1; @(posedge clk);
    rsp_en = 1'b0;
    #1;
    n_cmp++; if (tag_write_wen !== want) begin n_bad++; $display("FAIL err_wr got %0b want %0b", tag_write_wen, want); end
    @(posedge clk);
    #1; @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_drain busy got %0b want 0", busy); end
    @(posedge clk);
  endtask

  task automatic test_rst_mid;
    lk_en = 1'b1; lk_addr = 37'h3000;
    #1; @(posedge clk);
    lk_en = 1'b0;
    #1; @(posedge clk);
    rst = 1'b1;
    #1; @(posedge clk);
    rst = 1'b0; rsp_en = 1'b1; rsp_id = 2'd0;
    #1;
    n_cmp++; if (tag_init !== 1'b1 || busy !== 1'b1 || req_en !== 1'b0 || tag_write_addr !== 37'd0) begin n_bad++; $display("FAIL rst_mid got init=%0b busy=%0b req=%0b addr=%0d want 1/1/0/0", tag_init, busy, req_en, tag_write_addr); end
    @(posedge clk);
    rsp_en = 1'b0;
    #1;
    n_cmp++; if (tag_write_wen !== 1'b0 || tag_write_addr !== 37'd1) begin n_bad++; $display("FAIL rst_restart got wen=%0b addr=%0d want 0/1", tag_write_wen, tag_write_addr); end
    repeat (127) @(posedge clk);
    #1;
    n_cmp++; if (tag_init !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_cleared got init=%0b busy=%0b want 0/0", tag_init, busy); end
    @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_init;
    test_single_miss;
    test_expunge;
    test_back_to_back;
    test_stall;
    test_err;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
